// File: rtl/enigma_frame_codec.sv
// enigma_frame_codec
// UART-side frame codec for the Enigma encryptor.
//   RX: ASCII bytes -> 6-bit symbol codes, packed MS-first into frames of
//       N_CHARS characters; CR/LF may flush a short, left-aligned frame.
//   TX: walks a frame of codes MS-first, converts each code back to ASCII and
//       hands it to the UART one byte at a time.
//
// Handshakes:
//   rx_valid    : one-cycle strobe; rx_data is consumed on every rising edge
//                 where rx_valid=1, with no back-pressure.
//   frame_valid : one-cycle pulse; frame_out/frame_len/frame_err are valid in
//                 that cycle and hold until the next pulse.
//   tx_start    : accepted only on an edge where tx_ready=1.
//   tx_stb      : one-cycle strobe with tx_data valid. The UART answers by
//                 raising tx_busy; the next byte is strobed only after tx_busy
//                 has been seen high and then low again.
//   tx_done     : one-cycle pulse after the final byte has completed.

module enigma_frame_codec #(
    parameter int N_CHARS   = 10,
    parameter bit EOL_FLUSH = 1'b1,
    localparam int LW       = $clog2(N_CHARS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [8*N_CHARS-1:0] frame_out,
    output logic [LW-1:0]        frame_len,
    output logic                 frame_valid,
    output logic                 frame_err,
    input  logic [8*N_CHARS-1:0] tx_frame,
    input  logic                 tx_start,
    output logic                 tx_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_stb,
    input  logic                 tx_busy,
    output logic                 tx_done,
    output logic [2:0]           dbg_tx_state
);

    localparam int FW = 8 * N_CHARS;
    localparam int CW = $clog2(N_CHARS);

    localparam logic [7:0] INVALID_CODE = 8'hFF;

    // ------------------------------------------------------------------
    // Code map helpers
    // ------------------------------------------------------------------
    function automatic logic [7:0] f_ascii_to_code(input logic [7:0] b);
        logic [7:0] code;
        code = INVALID_CODE;
        if (b >= 8'h30 && b <= 8'h39)      code = b - 8'h30;   // '0'-'9'
        else if (b >= 8'h41 && b <= 8'h5A) code = b - 8'h37;   // 'A'-'Z'
        else if (b >= 8'h61 && b <= 8'h7A) code = b - 8'h3D;   // 'a'-'z'
        else if (b == 8'h3F)               code = 8'h3E;       // '?'
        else if (b == 8'h21)               code = 8'h3F;       // '!'
        return code;
    endfunction

    function automatic logic [7:0] f_code_to_ascii(input logic [7:0] c);
        logic [7:0] ch;
        ch = 8'h3F;                                            // out of range -> '?'
        if (c <= 8'h09)      ch = c + 8'h30;
        else if (c <= 8'h23) ch = c + 8'h37;
        else if (c <= 8'h3D) ch = c + 8'h3D;
        else if (c == 8'h3E) ch = 8'h3F;
        else if (c == 8'h3F) ch = 8'h21;
        return ch;
    endfunction

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic [FW-1:0] r_shift;
    logic [CW-1:0] r_cnt;
    logic          r_flag;
    logic [FW-1:0] r_frame_out;
    logic [LW-1:0] r_frame_len;
    logic          r_frame_valid;
    logic          r_frame_err;

    logic [7:0]    w_code;
    logic          w_invalid;
    logic          w_is_eol;
    logic          w_last;
    logic [FW-1:0] w_shift_next;
    logic [31:0]   w_pad_bits;
    logic [FW-1:0] w_flush_frame;

    // Decode the incoming byte and prepare both the shifted and flushed frames
    always_comb begin
        w_code        = f_ascii_to_code(rx_data);
        w_invalid     = (w_code == INVALID_CODE);
        w_is_eol      = EOL_FLUSH && ((rx_data == 8'h0D) || (rx_data == 8'h0A));
        w_last        = (r_cnt == CW'(N_CHARS - 1));
        w_shift_next  = {r_shift[FW-9:0], w_code};
        // Short frames hold their characters in the low bytes; shifting the
        // unused byte count up left-aligns them and zero-fills the tail.
        w_pad_bits    = 32'((N_CHARS - int'(r_cnt)) * 8);
        w_flush_frame = r_shift << w_pad_bits;
    end

    // Accumulate characters and publish a frame on the last char or on EOL
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift       <= '0;
            r_cnt         <= '0;
            r_flag        <= 1'b0;
            r_frame_out   <= '0;
            r_frame_len   <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            if (rx_valid) begin
                if (w_is_eol) begin
                    // An EOL on an empty frame is silently dropped
                    if (r_cnt != '0) begin
                        r_frame_out   <= w_flush_frame;
                        r_frame_len   <= LW'(r_cnt);
                        r_frame_err   <= r_flag;
                        r_frame_valid <= 1'b1;
                        r_shift       <= '0;
                        r_cnt         <= '0;
                        r_flag        <= 1'b0;
                    end
                end else if (w_last) begin
                    r_frame_out   <= w_shift_next;
                    r_frame_len   <= LW'(N_CHARS);
                    r_frame_err   <= r_flag | w_invalid;
                    r_frame_valid <= 1'b1;
                    r_shift       <= '0;
                    r_cnt         <= '0;
                    r_flag        <= 1'b0;
                end else begin
                    r_shift <= w_shift_next;
                    r_cnt   <= r_cnt + CW'(1);
                    r_flag  <= r_flag | w_invalid;
                end
            end
        end
    end

    assign frame_out   = r_frame_out;
    assign frame_len   = r_frame_len;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;

    // ------------------------------------------------------------------
    // TX serializer
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND      = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_IDLE = 3'd3,
        S_DONE      = 3'd4
    } tx_state_t;

    tx_state_t     r_state;
    tx_state_t     w_next_state;
    logic [FW-1:0] r_tx_frame;
    logic [CW-1:0] r_idx;
    logic          w_idx_last;

    logic          w_tx_ready;
    logic [7:0]    w_tx_data;
    logic          w_tx_stb;
    logic          w_tx_done;

    assign w_idx_last = (r_idx == CW'(N_CHARS - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (tx_start) w_next_state = S_SEND;
            S_SEND:      w_next_state = S_WAIT_BUSY;
            S_WAIT_BUSY: if (tx_busy) w_next_state = S_WAIT_IDLE;
            S_WAIT_IDLE: if (!tx_busy) w_next_state = w_idx_last ? S_DONE : S_SEND;
            S_DONE:      w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // Latch the frame on start, consume one byte per SEND, count completed bytes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_frame <= '0;
            r_idx      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (tx_start) begin
                        r_tx_frame <= tx_frame;
                        r_idx      <= '0;
                    end
                end
                S_SEND:      r_tx_frame <= r_tx_frame << 8;
                S_WAIT_IDLE: if (!tx_busy) r_idx <= r_idx + CW'(1);
                default:     ;
            endcase
        end
    end

    // Output decode from the current state
    always_comb begin
        w_tx_ready = 1'b0;
        w_tx_stb   = 1'b0;
        w_tx_done  = 1'b0;
        w_tx_data  = 8'h00;
        case (r_state)
            S_IDLE: w_tx_ready = 1'b1;
            S_SEND: begin
                w_tx_stb  = 1'b1;
                w_tx_data = f_code_to_ascii(r_tx_frame[FW-1 -: 8]);
            end
            S_DONE:  w_tx_done = 1'b1;
            default: ;
        endcase
    end

    assign tx_ready     = w_tx_ready;
    assign tx_data      = w_tx_data;
    assign tx_stb       = w_tx_stb;
    assign tx_done      = w_tx_done;
    assign dbg_tx_state = r_state;

endmodule

// File: tb/tb_enigma_frame_codec.sv
// Bench for enigma_frame_codec (N_CHARS=10, EOL_FLUSH=1).
// Stimulus pushes expected frames / bytes into queues; monitors pop and compare.

module tb_enigma_frame_codec;

    localparam int N  = 10;
    localparam int FW = 8 * N;
    localparam int LW = $clog2(N + 1);
    localparam int EW = 1 + LW + FW;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [FW-1:0] frame_out;
    logic [LW-1:0] frame_len;
    logic          frame_valid;
    logic          frame_err;
    logic [FW-1:0] tx_frame;
    logic          tx_start;
    logic          tx_ready;
    logic [7:0]    tx_data;
    logic          tx_stb;
    logic          tx_busy;
    logic          tx_done;
    logic [2:0]    dbg_tx_state;

    always #5 clk = ~clk;

    enigma_frame_codec #(.N_CHARS(N), .EOL_FLUSH(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .frame_out    (frame_out),
        .frame_len    (frame_len),
        .frame_valid  (frame_valid),
        .frame_err    (frame_err),
        .tx_frame     (tx_frame),
        .tx_start     (tx_start),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .tx_stb       (tx_stb),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .dbg_tx_state (dbg_tx_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int n_checks    = 0;
    int n_errors    = 0;
    int frames_seen = 0;
    int done_seen   = 0;

    logic [EW-1:0] exp_rx_q[$];
    logic [7:0]    exp_tx_q[$];

    localparam logic [FW-1:0] F_HELLO = 80'h11_28_2F_2F_32_20_32_35_2F_27;
    localparam logic [FW-1:0] F_AB    = 80'h0A_25_3E_00_00_00_00_00_00_00;
    localparam logic [FW-1:0] F_ERR   = 80'h24_25_FF_27_28_29_2A_2B_2C_2D;
    localparam logic [FW-1:0] F_DIG   = 80'h00_01_02_03_04_05_06_07_08_09;
    localparam logic [FW-1:0] F_TX    = 80'h00_0A_24_3E_3F_09_23_3D_40_FF;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            rx_data  = s[i];
            rx_valid = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic push_rx(input logic err, input logic [LW-1:0] len, input logic [FW-1:0] f);
        exp_rx_q.push_back({err, len, f});
    endtask

    task automatic push_tx_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_tx_q.push_back(s[i]);
    endtask

    task automatic start_tx(input logic [FW-1:0] f);
        for (int i = 0; i < 50; i++) begin
            if (tx_ready) break;
            @(negedge clk);
        end
        check("tx_ready_before_start", tx_ready, 1);
        tx_frame = f;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("tx_stb_latency", tx_stb, 1);
    endtask

    task automatic wait_tx_done(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_done) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, got, 1);
        @(negedge clk);
        check({tag, "_ready_after_done"}, tx_ready, 1);
        check({tag, "_done_one_cycle"}, tx_done, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_frame_out"},   frame_out,    0);
        check({tag, "_frame_len"},   frame_len,    0);
        check({tag, "_frame_valid"}, frame_valid,  0);
        check({tag, "_frame_err"},   frame_err,    0);
        check({tag, "_tx_ready"},    tx_ready,     1);
        check({tag, "_tx_data"},     tx_data,      0);
        check({tag, "_tx_stb"},      tx_stb,       0);
        check({tag, "_tx_done"},     tx_done,      0);
        check({tag, "_tx_state"},    dbg_tx_state, 0);
    endtask

    // ------------------------------------------------------------------
    // UART model: busy rises one cycle after a strobe, stays high 5 cycles
    // ------------------------------------------------------------------
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_stb) begin
                @(negedge clk);
                tx_busy = 1'b1;
                repeat (5) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitors
    // ------------------------------------------------------------------
    initial begin
        logic [EW-1:0] exp_f;
        logic [7:0]    exp_b;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (frame_valid) begin
                    frames_seen++;
                    if (exp_rx_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL rx_unexpected_frame: got %0h expected none",
                                 {frame_err, frame_len, frame_out});
                    end else begin
                        exp_f = exp_rx_q.pop_front();
                        check("rx_frame", {frame_err, frame_len, frame_out}, exp_f);
                    end
                end
                if (tx_stb) begin
                    if (exp_tx_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL tx_unexpected_stb: got %0h expected none", tx_data);
                    end else begin
                        exp_b = exp_tx_q.pop_front();
                        check("tx_byte", tx_data, exp_b);
                    end
                end
                if (tx_done) done_seen++;
            end
        end
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        rst      = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_frame = '0;
        tx_start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst = 1'b1;
        @(negedge clk);

        // Full frame, back-to-back characters
        push_rx(1'b0, 4'd10, F_HELLO);
        send_str("HelloWorld");
        repeat (2) @(negedge clk);

        // Short frame flushed by CR; lone LF afterwards must not pulse
        push_rx(1'b0, 4'd3, F_AB);
        send_str("Ab?");
        send_byte(8'h0D);
        repeat (2) @(negedge clk);
        send_byte(8'h0A);
        repeat (3) @(negedge clk);
        check("hold_frame_out", frame_out, F_AB);
        check("hold_frame_len", frame_len, 3);
        check("hold_frames_seen", frames_seen, 2);

        // Invalid char frame, immediately followed by a clean frame
        push_rx(1'b1, 4'd10, F_ERR);
        push_rx(1'b0, 4'd10, F_DIG);
        send_str("ab#defghij0123456789");
        repeat (3) @(negedge clk);

        // Transmit with a start pulse mid-transmit that must be ignored
        push_tx_str("0Aa?!9Zz??");
        start_tx(F_TX);
        repeat (8) @(negedge clk);
        check("tx_ready_busy", tx_ready, 0);
        tx_frame = '1;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        wait_tx_done("tx1");

        // Reset mid-RX (4 chars in) and mid-TX (4th byte in flight)
        send_str("abcd");
        push_tx_str("0Aa?!9Zz??");
        start_tx(F_TX);
        for (int i = 0; i < 200; i++) begin
            if (exp_tx_q.size() <= 6) break;
            @(negedge clk);
        end
        check("tx_progress_before_reset", exp_tx_q.size(), 6);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        #1 check_reset_values("mid");
        exp_tx_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("release_no_pulse", frame_valid, 0);

        // Fresh frame after reset must start from character 0
        push_rx(1'b0, 4'd10, F_HELLO);
        send_str("HelloWorld");
        repeat (2) @(negedge clk);

        // Fresh transmit after reset must start from byte 0
        for (int i = 0; i < 20; i++) begin
            if (!tx_busy) break;
            @(negedge clk);
        end
        push_tx_str("0Aa?!9Zz??");
        start_tx(F_TX);
        wait_tx_done("tx2");

        repeat (5) @(negedge clk);
        check("rx_frames_total", frames_seen, 5);
        check("rx_queue_empty", exp_rx_q.size(), 0);
        check("tx_queue_empty", exp_tx_q.size(), 0);
        check("tx_done_total", done_seen, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
